axi_crossbar_wrr_arbiter: RTL and testbench



---
 rtl/axi_crossbar_pkg.sv | 21 ++
 rtl/axi_crossbar_rr_pick.sv | 32 +++
 rtl/axi_crossbar_wrr_arbiter.sv | 125 ++++++++++++
 tb/tb_axi_crossbar_wrr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_crossbar_pkg.sv
// Shared definitions for the crossbar request arbiter.
// Mode encodings, FSM states and a constant-safe clog2.
package axi_crossbar_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int ARB_WRR   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axi_crossbar_rr_pick.sv
// Rotating priority encoder: first set request at or above
// the start pointer, wrapping modulo N.
import axi_crossbar_pkg::*;

module axi_crossbar_rr_pick #(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx
);

  logic w_hit;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_hit    = 1'b0;
    for (int i = 0; i < N; i++) begin
      automatic int j = int'(i_ptr) + i;
      if (j >= N) j -= N;
      if (!w_hit && i_req[j]) begin
        w_hit       = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/axi_crossbar_wrr_arbiter.sv
// Locked one-hot grant arbiter: fixed, round-robin or
// weighted round-robin winner selection.
import axi_crossbar_pkg::*;

module axi_crossbar_wrr_arbiter #(
  parameter int AXI_REQUEST_NUM = 4,
  parameter int WEIGHT_WIDTH    = 4,
  parameter int ARB_MODE        = 2,
  localparam int N  = AXI_REQUEST_NUM,
  localparam int IW = clog2(AXI_REQUEST_NUM),
  localparam int WW = WEIGHT_WIDTH
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic [N-1:0]  requests_i,
  input  logic          release_i,
  input  logic [N*WW-1:0] weights_i,
  output logic [N-1:0]  arbiter_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_valid_o
);

  arb_state_e    r_state, w_state_nxt;
  logic [N-1:0]  r_arb, w_arb_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [WW-1:0] r_credit, w_credit_nxt;

  logic [IW-1:0] w_pick_ptr;
  logic [N-1:0]  w_onehot;
  logic [IW-1:0] w_idx;
  logic [WW-1:0] w_wt;
  logic [WW-1:0] w_cred_eff;
  logic          w_hold;
  logic          w_abandon;

  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] i);
    return (i == IW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  assign w_pick_ptr = (ARB_MODE == ARB_FIXED) ? '0 : r_ptr;

  axi_crossbar_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_req    (requests_i),
    .i_ptr    (w_pick_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  // Credit only carries over while the pointer holder wins again.
  always_comb begin
    w_wt = '0;
    for (int k = 0; k < N; k++) begin
      if (w_idx == IW'(k)) w_wt = weights_i[k*WW +: WW];
    end
    if (w_wt == '0) w_wt = WW'(1);
    w_cred_eff = (w_idx == r_ptr) ? r_credit : '0;
    w_hold     = ({1'b0, w_cred_eff} + 1'b1) < {1'b0, w_wt};
  end

  assign w_abandon = ~|(requests_i & r_arb);

  always_comb begin
    w_state_nxt  = r_state;
    w_arb_nxt    = r_arb;
    w_idx_nxt    = r_idx;
    w_ptr_nxt    = r_ptr;
    w_credit_nxt = r_credit;
    unique case (r_state)
      ST_IDLE: begin
        if (|requests_i) begin
          w_state_nxt = ST_GRANT;
          w_arb_nxt   = w_onehot;
          w_idx_nxt   = w_idx;
          if (ARB_MODE == ARB_RR) begin
            w_ptr_nxt = f_inc(w_idx);
          end else if (ARB_MODE == ARB_WRR) begin
            if (w_hold) begin
              w_ptr_nxt    = w_idx;
              w_credit_nxt = w_cred_eff + 1'b1;
            end else begin
              w_ptr_nxt    = f_inc(w_idx);
              w_credit_nxt = '0;
            end
          end
        end
      end
      ST_GRANT: begin
        if (release_i || w_abandon) begin
          w_state_nxt = ST_IDLE;
          w_arb_nxt   = '0;
          // An abandoned grant forfeits the rest of its weight.
          if (!release_i && ARB_MODE == ARB_WRR) begin
            w_ptr_nxt    = f_inc(r_idx);
            w_credit_nxt = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= ST_IDLE;
      r_arb    <= '0;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_credit <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_arb    <= w_arb_nxt;
      r_idx    <= w_idx_nxt;
      r_ptr    <= w_ptr_nxt;
      r_credit <= w_credit_nxt;
    end
  end

  assign arbiter_o     = r_arb;
  assign grant_idx_o   = r_idx;
  assign grant_valid_o = |r_arb;

endmodule

// File: tb/tb_axi_crossbar_wrr_arbiter.sv
// Bench for the crossbar arbiter: one instance per mode
// (0 fixed, 1 round-robin, 2 weighted), scoreboarded grants.
module tb_axi_crossbar_wrr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req [3];
  logic       rel [3];
  logic [15:0] wts [3];
  logic [3:0] arb [3];
  logic [1:0] idx [3];
  logic       vld [3];

  typedef struct {
    logic [3:0] arb;
    logic [1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    axi_crossbar_wrr_arbiter #(
      .AXI_REQUEST_NUM (4),
      .WEIGHT_WIDTH    (4),
      .ARB_MODE        (m)
    ) u_dut (
      .ACLK          (clk),
      .ARESETN       (rst_n),
      .requests_i    (req[m]),
      .release_i     (rel[m]),
      .weights_i     (wts[m]),
      .arbiter_o     (arb[m]),
      .grant_idx_o   (idx[m]),
      .grant_valid_o (vld[m])
    );
  end

  task automatic push(input logic [3:0] a);
    exp_t e;
    e.arb = a;
    e.idx = 2'd0;
    for (int k = 0; k < 4; k++) if (a[k]) e.idx = 2'(k);
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input int m, output logic [3:0] a,
                            output logic [1:0] i, output bit to);
    to = 1'b1;
    a  = '0;
    i  = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (vld[m]) begin
        a  = arb[m];
        i  = idx[m];
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset_rr;
    logic [3:0] a;
    logic [1:0] i;
    bit to;
    exp_t e;
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n  = 1'b0;
    req[1] = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      n_run++;
      if (arb[1] !== 4'b0 || vld[1] !== 1'b0 || idx[1] !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_hold: arb=%b vld=%b idx=%0d want 0000/0/0",
                 arb[1], vld[1], idx[1]);
      end
    end
    foreach (seq[k]) push(seq[k]);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(1, a, i, to);
      e = exp_q.pop_front();
      n_run++;
      if (to || a !== e.arb || i !== e.idx) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: arb=%b idx=%0d to=%0b want %b/%0d",
                 k, a, i, to, e.arb, e.idx);
      end
      rel[1] = 1'b1;
      @(negedge clk);
      rel[1] = 1'b0;
      n_run++;
      if (vld[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle_gap[%0d]: vld=%b want 0", k, vld[1]);
      end
    end
    req[1] = 4'b0000;
  endtask

  task automatic test_lock;
    logic [3:0] a;
    logic [1:0] i;
    bit to;
    exp_t e;
    req[1] = 4'b0100;
    push(4'b0100);
    wait_grant(1, a, i, to);
    e = exp_q.pop_front();
    n_run++;
    if (to || a !== e.arb || i !== e.idx) begin
      n_fail++;
      $display("FAIL lock_first: arb=%b idx=%0d to=%0b want %b/%0d",
               a, i, to, e.arb, e.idx);
    end
    req[1] = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_run++;
      if (arb[1] !== 4'b0100) begin
        n_fail++;
        $display("FAIL lock_hold[%0d]: arb=%b want 0100", c, arb[1]);
      end
    end
    rel[1] = 1'b1;
    @(negedge clk);
    rel[1] = 1'b0;
    n_run++;
    if (arb[1] !== 4'b0000) begin
      n_fail++;
      $display("FAIL lock_release: arb=%b want 0000", arb[1]);
    end
    push(4'b1000);
    wait_grant(1, a, i, to);
    e = exp_q.pop_front();
    n_run++;
    if (to || a !== e.arb || i !== e.idx) begin
      n_fail++;
      $display("FAIL lock_next: arb=%b idx=%0d to=%0b want %b/%0d",
               a, i, to, e.arb, e.idx);
    end
    rel[1] = 1'b1;
    req[1] = 4'b0000;
    @(negedge clk);
    rel[1] = 1'b0;
  endtask

  task automatic test_weighted;
    logic [3:0] a;
    logic [1:0] i;
    bit to;
    exp_t e;
    logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100,
                            4'b0100, 4'b0100, 4'b1000, 4'b0001};
    wts[2] = 16'h0321;
    req[2] = 4'b1111;
    foreach (seq[k]) push(seq[k]);
    for (int k = 0; k < 8; k++) begin
      wait_grant(2, a, i, to);
      e = exp_q.pop_front();
      n_run++;
      if (to || a !== e.arb || i !== e.idx) begin
        n_fail++;
        $display("FAIL wrr_seq[%0d]: arb=%b idx=%0d to=%0b want %b/%0d",
                 k, a, i, to, e.arb, e.idx);
      end
      rel[2] = 1'b1;
      @(negedge clk);
      rel[2] = 1'b0;
      n_run++;
      if (vld[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL wrr_idle_gap[%0d]: vld=%b want 0", k, vld[2]);
      end
    end
    req[2] = 4'b0000;
  endtask

  task automatic test_abandon;
    logic [3:0] a;
    logic [1:0] i;
    bit to;
    exp_t e;
    logic [3:0] rq [4] = '{4'b0010, 4'b0101, 4'b0010, 4'b0011};
    logic [3:0] ex [4] = '{4'b0010, 4'b0100, 4'b0010, 4'b0001};
    wts[2] = 16'h0331;
    for (int k = 0; k < 4; k++) begin
      req[2] = rq[k];
      push(ex[k]);
      wait_grant(2, a, i, to);
      e = exp_q.pop_front();
      n_run++;
      if (to || a !== e.arb || i !== e.idx) begin
        n_fail++;
        $display("FAIL abandon_seq[%0d]: arb=%b idx=%0d to=%0b want %b/%0d",
                 k, a, i, to, e.arb, e.idx);
      end
      if (k[0] == 1'b0) begin
        req[2] = 4'b0000;
        @(negedge clk);
        n_run++;
        if (arb[2] !== 4'b0000) begin
          n_fail++;
          $display("FAIL abandon_clear[%0d]: arb=%b want 0000", k, arb[2]);
        end
      end else begin
        rel[2] = 1'b1;
        req[2] = 4'b0000;
        @(negedge clk);
        rel[2] = 1'b0;
      end
    end
  endtask

  task automatic test_fixed;
    logic [3:0] a;
    logic [1:0] i;
    bit to;
    exp_t e;
    req[0] = 4'b1100;
    push(4'b0100);
    wait_grant(0, a, i, to);
    e = exp_q.pop_front();
    n_run++;
    if (to || a !== e.arb || i !== e.idx) begin
      n_fail++;
      $display("FAIL fixed_first: arb=%b idx=%0d to=%0b want %b/%0d",
               a, i, to, e.arb, e.idx);
    end
    req[0] = 4'b1110;
    @(negedge clk);
    n_run++;
    if (arb[0] !== 4'b0100) begin
      n_fail++;
      $display("FAIL fixed_lock: arb=%b want 0100", arb[0]);
    end
    rel[0] = 1'b1;
    @(negedge clk);
    rel[0] = 1'b0;
    n_run++;
    if (vld[0] !== 1'b0 || idx[0] !== 2'd2) begin
      n_fail++;
      $display("FAIL fixed_idx_hold: vld=%b idx=%0d want 0/2", vld[0], idx[0]);
    end
    push(4'b0010);
    wait_grant(0, a, i, to);
    e = exp_q.pop_front();
    n_run++;
    if (to || a !== e.arb || i !== e.idx) begin
      n_fail++;
      $display("FAIL fixed_next: arb=%b idx=%0d to=%0b want %b/%0d",
               a, i, to, e.arb, e.idx);
    end
    rel[0] = 1'b1;
    req[0] = 4'b0000;
    @(negedge clk);
    rel[0] = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [3:0] a;
    logic [1:0] i;
    bit to;
    exp_t e;
    req[1] = 4'b0100;
    push(4'b0100);
    wait_grant(1, a, i, to);
    e = exp_q.pop_front();
    n_run++;
    if (to || a !== e.arb || i !== e.idx) begin
      n_fail++;
      $display("FAIL areset_pre: arb=%b idx=%0d to=%0b want %b/%0d",
               a, i, to, e.arb, e.idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (arb[1] !== 4'b0000 || vld[1] !== 1'b0 || idx[1] !== 2'd0) begin
      n_fail++;
      $display("FAIL areset_clear: arb=%b vld=%b idx=%0d want 0000/0/0",
               arb[1], vld[1], idx[1]);
    end
    req[1] = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(4'b0001);
    wait_grant(1, a, i, to);
    e = exp_q.pop_front();
    n_run++;
    if (to || a !== e.arb || i !== e.idx) begin
      n_fail++;
      $display("FAIL areset_first: arb=%b idx=%0d to=%0b want %b/%0d",
               a, i, to, e.arb, e.idx);
    end
    rel[1] = 1'b1;
    req[1] = 4'b0000;
    @(negedge clk);
    rel[1] = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      req[m] = 4'b0000;
      rel[m] = 1'b0;
      wts[m] = 16'h0000;
    end
    test_reset_rr();
    test_lock();
    test_weighted();
    test_abandon();
    test_fixed();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
